// File: rtl/sgpr_rd_port_arbiter.sv
// rtl/sgpr_rd_port_arbiter.sv - round-robin SGPR read-port arbiter with tagged response routing
module sgpr_rd_port_arbiter #(
    parameter int RD_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic         req1_valid,
    input  logic         req2_valid,
    input  logic [8:0]   req0_addr,
    input  logic [8:0]   req1_addr,
    input  logic [8:0]   req2_addr,
    output logic         req0_ready,
    output logic         req1_ready,
    output logic         req2_ready,
    output logic         port0_rd_en,
    output logic         port1_rd_en,
    output logic         port2_rd_en,
    output logic [8:0]   port0_rd_addr,
    output logic [8:0]   port1_rd_addr,
    output logic [8:0]   port2_rd_addr,
    input  logic [127:0] port_rd_data,
    output logic         rsp0_valid,
    output logic         rsp1_valid,
    output logic         rsp2_valid,
    output logic [127:0] rsp_data
);

    logic [1:0]   r_ptr;
    logic [2:0]   r_en;
    logic [8:0]   r_addr0;
    logic [8:0]   r_addr1;
    logic [8:0]   r_addr2;
    logic [2:0]   r_tag [RD_LATENCY];
    logic [2:0]   r_rsp_valid;
    logic [127:0] r_rsp_data;

    logic [2:0]   w_grant;
    logic [1:0]   w_ptr_nxt;

    // Priority order starts at r_ptr and wraps mod 3; r_ptr never holds 3.
    always_comb begin
        w_grant = 3'b000;
        case (r_ptr)
            2'd1: begin
                if (req1_valid)      w_grant = 3'b010;
                else if (req2_valid) w_grant = 3'b100;
                else if (req0_valid) w_grant = 3'b001;
            end
            2'd2: begin
                if (req2_valid)      w_grant = 3'b100;
                else if (req0_valid) w_grant = 3'b001;
                else if (req1_valid) w_grant = 3'b010;
            end
            default: begin
                if (req0_valid)      w_grant = 3'b001;
                else if (req1_valid) w_grant = 3'b010;
                else if (req2_valid) w_grant = 3'b100;
            end
        endcase
    end

    always_comb begin
        w_ptr_nxt = r_ptr;
        if (w_grant[0])      w_ptr_nxt = 2'd1;
        else if (w_grant[1]) w_ptr_nxt = 2'd2;
        else if (w_grant[2]) w_ptr_nxt = 2'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr       <= 2'd0;
            r_en        <= 3'b000;
            r_addr0     <= 9'd0;
            r_addr1     <= 9'd0;
            r_addr2     <= 9'd0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_tag[i] <= 3'b000;
            end
            r_rsp_valid <= 3'b000;
            r_rsp_data  <= 128'd0;
        end else begin
            r_ptr   <= w_ptr_nxt;
            r_en    <= w_grant;
            r_addr0 <= w_grant[0] ? req0_addr : 9'd0;
            r_addr1 <= w_grant[1] ? req1_addr : 9'd0;
            r_addr2 <= w_grant[2] ? req2_addr : 9'd0;
            // The tag trails the issue register so the last stage lines up with valid mux data.
            r_tag[0] <= r_en;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            r_rsp_valid <= r_tag[RD_LATENCY-1];
            if (|r_tag[RD_LATENCY-1]) begin
                r_rsp_data <= port_rd_data;
            end
        end
    end

    assign req0_ready    = w_grant[0];
    assign req1_ready    = w_grant[1];
    assign req2_ready    = w_grant[2];
    assign port0_rd_en   = r_en[0];
    assign port1_rd_en   = r_en[1];
    assign port2_rd_en   = r_en[2];
    assign port0_rd_addr = r_addr0;
    assign port1_rd_addr = r_addr1;
    assign port2_rd_addr = r_addr2;
    assign rsp0_valid    = r_rsp_valid[0];
    assign rsp1_valid    = r_rsp_valid[1];
    assign rsp2_valid    = r_rsp_valid[2];
    assign rsp_data      = r_rsp_data;

endmodule
